// File: rtl/register_file.sv
// register_file: architectural register file with three combinational read
// ports (with write-through bypass), one byte-enabled write port, and a
// program-counter entry that auto-increments and reads back with an offset.
module register_file #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned PC_INDEX   = 15,
    parameter int unsigned PC_STEP    = 4,
    parameter int unsigned PC_OFFSET  = 8,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [ADDR_WIDTH-1:0]   rd_addr_a,
    input  logic [ADDR_WIDTH-1:0]   rd_addr_b,
    input  logic [ADDR_WIDTH-1:0]   rd_addr_c,
    output logic [WIDTH-1:0]        rd_data_a,
    output logic [WIDTH-1:0]        rd_data_b,
    output logic [WIDTH-1:0]        rd_data_c,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic [WIDTH/8-1:0]      wr_be,
    input  logic                    pc_en,
    output logic [WIDTH-1:0]        pc
);

    localparam int unsigned NUM_REGS  = 2 ** ADDR_WIDTH;
    localparam int unsigned NUM_BYTES = WIDTH / 8;

    localparam logic [ADDR_WIDTH-1:0] PC_ADDR     = ADDR_WIDTH'(PC_INDEX);
    localparam logic [WIDTH-1:0]      PC_STEP_W   = WIDTH'(PC_STEP);
    localparam logic [WIDTH-1:0]      PC_OFFSET_W = WIDTH'(PC_OFFSET);
    localparam logic [WIDTH-1:0]      RESET_PC_W  = WIDTH'(RESET_PC);

    // Entry PC_ADDR of the array is the program counter itself.
    logic [WIDTH-1:0] regs_q [NUM_REGS];
    logic [WIDTH-1:0] regs_d [NUM_REGS];

    logic             wr_fire;
    logic             pc_written;
    logic [WIDTH-1:0] wr_merged;

    // Replace the enabled bytes of old_val with the matching bytes of new_val.
    function automatic logic [WIDTH-1:0] byte_merge(
        input logic [WIDTH-1:0]     old_val,
        input logic [WIDTH-1:0]     new_val,
        input logic [NUM_BYTES-1:0] be
    );
        logic [WIDTH-1:0] result;
        result = old_val;
        for (int i = 0; i < int'(NUM_BYTES); i++) begin
            if (be[i]) result[8*i +: 8] = new_val[8*i +: 8];
        end
        return result;
    endfunction

    // Gating with rst keeps the bypass path quiet while reset is held, so
    // reads show the cleared state rather than a pending write.
    assign wr_fire    = enable & wr_en & ~rst;
    assign pc_written = wr_fire & (wr_addr == PC_ADDR) & (|wr_be);
    assign wr_merged  = byte_merge(regs_q[wr_addr], wr_data, wr_be);
    assign pc         = regs_q[PC_ADDR];

    // One read port: PC slot reads with offset (no bypass), others bypass
    // the pending write so decode sees the post-edge value.
    function automatic logic [WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] addr);
        if (addr == PC_ADDR) begin
            return regs_q[PC_ADDR] + PC_OFFSET_W;
        end else if (wr_fire && (addr == wr_addr)) begin
            return wr_merged;
        end else begin
            return regs_q[addr];
        end
    endfunction

    // Combinational read ports, each independent of the others.
    always_comb begin
        rd_data_a = read_port(rd_addr_a);
        rd_data_b = read_port(rd_addr_b);
        rd_data_c = read_port(rd_addr_c);
    end

    // Next-state: byte-merged write first, then PC increment unless a real
    // (non-empty byte enable) write to the PC slot takes priority.
    always_comb begin
        // NOTE: start from the current state so every path assigns regs_d and no latch is inferred.
        regs_d = regs_q;
        if (wr_fire) begin
            regs_d[wr_addr] = wr_merged;
        end
        if (enable && pc_en && !pc_written) begin
            regs_d[PC_ADDR] = regs_q[PC_ADDR] + PC_STEP_W;
        end
    end

    // State register with asynchronous clear of every entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the whole array is reset because architectural state must read 0 after reset; this rules out a RAM macro.
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (i == PC_INDEX) ? RESET_PC_W : '0;
            end
        end else begin
            // NOTE: non-blocking assignment so all entries update together at the edge.
            regs_q <= regs_d;
        end
    end

endmodule
